// File: rtl/systolic_skew_stream.sv
// Systolic operand staging: per-lane delay lines with runtime skew/deskew selection,
// a ready/valid input and an automatic drain that flushes the triangle after IN_LAST.
module systolic_skew_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int SA_LENGTH  = 256,
    localparam int CNT_WIDTH = $clog2(SA_LENGTH) + 1
) (
    input  logic                             CLK,
    input  logic                             ASYNC_RST,
    input  logic                             SYNC_RST,
    input  logic                             MODE_DESKEW,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic                             IN_LAST,
    input  logic [DATA_WIDTH*SA_LENGTH-1:0]  Inputs,
    output logic [DATA_WIDTH*SA_LENGTH-1:0]  Outputs,
    output logic [SA_LENGTH-1:0]             Out_Valid,
    output logic                             DONE
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 mode;
    logic                 mode_next;
    logic                 done_next;
    logic                 adv;
    logic                 draining;
    logic                 mode_eff;

    // In the IDLE acceptance cycle the incoming mode already steers the lane taps.
    assign mode_eff = (state == IDLE) ? MODE_DESKEW : mode;

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            state <= IDLE;
            cnt   <= '0;
            mode  <= 1'b0;
            DONE  <= 1'b0;
        end else if (SYNC_RST) begin
            state <= IDLE;
            cnt   <= '0;
            mode  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            mode  <= mode_next;
            DONE  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mode_next  = mode;
        done_next  = 1'b0;
        draining   = (state == DRAIN);
        IN_READY   = (state != DRAIN);
        adv        = ((state != DRAIN) && IN_VALID) || (state == DRAIN);
        case (state)
            IDLE, STREAM: begin
                if (IN_VALID) begin
                    if (state == IDLE) begin
                        mode_next = MODE_DESKEW;
                    end
                    state_next = STREAM;
                    if (IN_LAST) begin
                        if (SA_LENGTH == 1) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = DRAIN;
                            cnt_next   = CNT_WIDTH'(SA_LENGTH - 1);
                        end
                    end
                end
            end
            DRAIN: begin
                cnt_next = cnt - CNT_WIDTH'(1);
                if (cnt == CNT_WIDTH'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Each lane keeps enough stages for the deeper of its two possible delays;
    // the tap is picked by the active mode, and a full drain flushes every stage.
    for (genvar r = 0; r < SA_LENGTH; r++) begin : g_lane
        localparam int DS    = r;
        localparam int DD    = SA_LENGTH - 1 - r;
        localparam int DEPTH = (DS > DD) ? DS : DD;

        logic [DATA_WIDTH-1:0] in_data;
        logic                  in_vld;
        logic [DATA_WIDTH-1:0] skew_data;
        logic                  skew_vld;
        logic [DATA_WIDTH-1:0] deskew_data;
        logic                  deskew_vld;

        assign in_data = draining ? '0 : Inputs[r*DATA_WIDTH +: DATA_WIDTH];
        assign in_vld  = ~draining;

        if (DEPTH > 0) begin : g_line
            logic [DATA_WIDTH-1:0] stage_data [DEPTH];
            logic [DEPTH-1:0]      stage_vld;

            always_ff @(posedge CLK or posedge ASYNC_RST) begin
                if (ASYNC_RST) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        stage_data[k] <= '0;
                    end
                    stage_vld <= '0;
                end else if (SYNC_RST) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        stage_data[k] <= '0;
                    end
                    stage_vld <= '0;
                end else if (adv) begin
                    stage_data[0] <= in_data;
                    stage_vld[0]  <= in_vld;
                    for (int k = 1; k < DEPTH; k++) begin
                        stage_data[k] <= stage_data[k-1];
                        stage_vld[k]  <= stage_vld[k-1];
                    end
                end
            end

            if (DS == 0) begin : g_skew_pass
                assign skew_data = in_data;
                assign skew_vld  = in_vld;
            end else begin : g_skew_tap
                assign skew_data = stage_data[DS-1];
                assign skew_vld  = stage_vld[DS-1];
            end

            if (DD == 0) begin : g_deskew_pass
                assign deskew_data = in_data;
                assign deskew_vld  = in_vld;
            end else begin : g_deskew_tap
                assign deskew_data = stage_data[DD-1];
                assign deskew_vld  = stage_vld[DD-1];
            end
        end else begin : g_pass
            assign skew_data   = in_data;
            assign skew_vld    = in_vld;
            assign deskew_data = in_data;
            assign deskew_vld  = in_vld;
        end

        assign Outputs[r*DATA_WIDTH +: DATA_WIDTH] = mode_eff ? deskew_data : skew_data;
        assign Out_Valid[r] = (mode_eff ? deskew_vld : skew_vld) & adv;
    end

endmodule

// File: tb/tb_systolic_skew_stream.sv
// Bench for systolic_skew_stream: directed and random streams against a lane-timing
// reference model, plus a single-lane instance for the SA_LENGTH=1 corner.
module tb_systolic_skew_stream;

    localparam int L  = 4;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          ASYNC_RST = 1'b0;
    logic          SYNC_RST = 1'b0;
    logic          MODE_DESKEW = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          IN_LAST = 1'b0;
    logic          IN_READY;
    logic          DONE;
    logic [DW*L-1:0] Inputs = '0;
    logic [DW*L-1:0] Outputs;
    logic [L-1:0]    Out_Valid;

    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_mode = 1'b0;
    logic          s_ready;
    logic          s_done;
    logic [DW-1:0] s_in = '0;
    logic [DW-1:0] s_out;
    logic [0:0]    s_ov;

    systolic_skew_stream #(.DATA_WIDTH(DW), .SA_LENGTH(L)) dut (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .MODE_DESKEW(MODE_DESKEW),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LAST(IN_LAST), .Inputs(Inputs),
        .Outputs(Outputs), .Out_Valid(Out_Valid), .DONE(DONE)
    );

    systolic_skew_stream #(.DATA_WIDTH(DW), .SA_LENGTH(1)) dut1 (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .MODE_DESKEW(s_mode),
        .IN_VALID(s_valid), .IN_READY(s_ready), .IN_LAST(s_last), .Inputs(s_in),
        .Outputs(s_out), .Out_Valid(s_ov), .DONE(s_done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference model: each accepted vector element is due on lane r at advancing-cycle
    // index (index of the accepting cycle) + d(r); a LAST accept is followed by L-1
    // drain cycles and then a single DONE cycle.
    typedef struct {
        logic [DW-1:0] data;
        int            adv;
    } exp_t;

    exp_t exp_q [L][$];
    int   adv_count = 0;
    int   cur_adv = -1;
    int   drain_left = 0;
    bit   done_pend = 1'b0;
    bit   in_stream = 1'b0;
    bit   mode_m = 1'b0;
    bit   exp_ready = 1'b1;
    bit   exp_done = 1'b0;
    bit   stall_now = 1'b0;
    bit   mon_en = 1'b0;

    function automatic int dly(input int r, input bit m);
        return m ? (L - 1 - r) : r;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < L; r++) exp_q[r].delete();
        drain_left = 0;
        done_pend  = 1'b0;
        in_stream  = 1'b0;
        mode_m     = 1'b0;
        cur_adv    = -1;
        exp_ready  = 1'b1;
        exp_done   = 1'b0;
        stall_now  = 1'b0;
    endtask

    // Called at posedge+1; drives one cycle and returns whether the vector was taken.
    task automatic step(input bit v, input bit l, input bit m, input logic [DW*L-1:0] data,
                        output bit acc);
        bit   adv;
        int   dl_next;
        bit   dn_next;
        exp_t e;
        IN_VALID    = v;
        IN_LAST     = l;
        MODE_DESKEW = m;
        Inputs      = data;
        exp_ready   = (drain_left == 0);
        exp_done    = done_pend;
        acc         = v && exp_ready;
        adv         = acc || (drain_left > 0);
        stall_now   = in_stream && !adv;
        dl_next     = drain_left;
        dn_next     = 1'b0;
        if (drain_left > 0) begin
            dl_next = drain_left - 1;
            if (dl_next == 0) dn_next = 1'b1;
        end else if (acc) begin
            if (!in_stream) begin
                mode_m    = m;
                in_stream = 1'b1;
            end
            for (int r = 0; r < L; r++) begin
                e.data = data[r*DW +: DW];
                e.adv  = adv_count + dly(r, mode_m);
                exp_q[r].push_back(e);
            end
            if (l) begin
                in_stream = 1'b0;
                if (L > 1) dl_next = L - 1;
                else dn_next = 1'b1;
            end
        end
        cur_adv = adv ? adv_count : -1;
        @(posedge CLK);
        #1;
        if (adv) adv_count++;
        drain_left = dl_next;
        done_pend  = dn_next;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom, acc);
    endtask

    task automatic send_vec(input bit l, input bit m, input logic [DW*L-1:0] data);
        bit acc;
        acc = 1'b0;
        while (!acc) step(1'b1, l, m, data, acc);
    endtask

    task automatic send_random_stream(input int n, input bit m, input int gap_pct);
        bit acc;
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct)
                step(1'b0, 1'b0, 1'($urandom), $urandom, acc);
            send_vec(i == n - 1, (i == 0) ? m : 1'($urandom), $urandom);
        end
    endtask

    task automatic async_pulse();
        mon_en   = 1'b0;
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        #1 ASYNC_RST = 1'b1;
        #1;
        chk("arst_out_valid", Out_Valid, 0);
        chk("arst_in_ready", IN_READY, 1);
        ASYNC_RST = 1'b0;
        model_reset();
        @(posedge CLK);
        #1 mon_en = 1'b1;
    endtask

    task automatic sync_pulse();
        mon_en   = 1'b0;
        IN_VALID = 1'b1;
        IN_LAST  = 1'b0;
        Inputs   = $urandom;
        SYNC_RST = 1'b1;
        @(posedge CLK);
        #1;
        SYNC_RST = 1'b0;
        IN_VALID = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever a lane presents valid data.
    exp_t            mon_e;
    logic [DW*L-1:0] prev_out = '0;
    bit              prev_stall = 1'b0;

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("in_ready", IN_READY, exp_ready);
            chk("done", DONE, exp_done);
            for (int r = 0; r < L; r++) begin
                if (Out_Valid[r]) begin
                    if (exp_q[r].size() == 0) begin
                        chk($sformatf("spurious_valid_lane%0d", r), 1, 0);
                    end else begin
                        mon_e = exp_q[r].pop_front();
                        chk($sformatf("data_lane%0d", r), Outputs[r*DW +: DW], mon_e.data);
                        chk($sformatf("timing_lane%0d", r), cur_adv, mon_e.adv);
                    end
                end else if (exp_q[r].size() > 0 && cur_adv >= 0 && exp_q[r][0].adv == cur_adv) begin
                    chk($sformatf("missing_valid_lane%0d", r), 0, 1);
                end
                if (stall_now && prev_stall && dly(r, mode_m) != 0)
                    chk($sformatf("stall_hold_lane%0d", r), Outputs[r*DW +: DW], prev_out[r*DW +: DW]);
            end
            prev_out   = Outputs;
            prev_stall = stall_now;
        end else begin
            prev_stall = 1'b0;
        end
    end

    logic [DW*L-1:0] v1, v2, v3;
    logic [DW*L-1:0] rv;
    bit              acc_d;

    initial begin
        v1 = {8'd4, 8'd3, 8'd2, 8'd1};
        v2 = {8'd8, 8'd7, 8'd6, 8'd5};
        v3 = {8'd12, 8'd11, 8'd10, 8'd9};
        rv = 32'hA5C3_7E19;

        #1 ASYNC_RST = 1'b1;
        Inputs = rv;
        @(posedge CLK);
        @(posedge CLK);
        #1 ASYNC_RST = 1'b0;
        #1;
        chk("reset_out_valid", Out_Valid, 0);
        chk("reset_in_ready", IN_READY, 1);
        chk("reset_done", DONE, 0);
        chk("reset_lane0_follows_input", Outputs[7:0], rv[7:0]);
        chk("reset_lanes123_zero", Outputs[31:8], 0);
        @(posedge CLK);
        #1;
        model_reset();
        mon_en = 1'b1;

        // Skew then deskew, back to back with idle gaps
        send_vec(1'b0, 1'b0, v1); send_vec(1'b0, 1'b0, v2); send_vec(1'b1, 1'b0, v3);
        idle(5);
        send_vec(1'b0, 1'b1, v1); send_vec(1'b0, 1'b1, v2); send_vec(1'b1, 1'b1, v3);
        idle(5);

        // Two-cycle stall between vectors
        send_vec(1'b0, 1'b0, v1);
        step(1'b0, 1'b0, 1'b1, $urandom, acc_d);
        step(1'b0, 1'b0, 1'b1, $urandom, acc_d);
        send_vec(1'b0, 1'b0, v2); send_vec(1'b1, 1'b0, v3);
        idle(5);

        // Next stream held valid through drain, accepted in the DONE cycle with new mode
        send_vec(1'b0, 1'b0, v1); send_vec(1'b1, 1'b0, v2);
        send_vec(1'b0, 1'b1, v3); send_vec(1'b1, 1'b1, v1);
        idle(5);

        // Asynchronous reset mid-drain, then a clean stream
        send_vec(1'b0, 1'b0, v1); send_vec(1'b1, 1'b0, v2);
        idle(1);
        async_pulse();
        idle(4);
        send_vec(1'b0, 1'b0, v1); send_vec(1'b0, 1'b0, v2); send_vec(1'b1, 1'b0, v3);
        idle(5);

        // Synchronous reset mid-stream with valid asserted
        send_vec(1'b0, 1'b1, v1); send_vec(1'b0, 1'b1, v2);
        sync_pulse();
        idle(5);

        // Randomized streams
        for (int s = 0; s < 40; s++) begin
            send_random_stream($urandom_range(1, 6), 1'($urandom), 30);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(6);
        mon_en = 1'b0;

        for (int r = 0; r < L; r++) chk($sformatf("scoreboard_empty_lane%0d", r), exp_q[r].size(), 0);

        // Single-lane instance: pass-through, DONE one cycle later, no drain
        s_valid = 1'b1; s_last = 1'b1; s_in = 8'd7;
        @(negedge CLK);
        chk("len1_out", s_out, 7);
        chk("len1_valid", s_ov, 1);
        chk("len1_ready", s_ready, 1);
        chk("len1_done_early", s_done, 0);
        @(posedge CLK);
        #1 s_valid = 1'b0; s_last = 1'b0;
        @(negedge CLK);
        chk("len1_done", s_done, 1);
        chk("len1_ready_after", s_ready, 1);
        chk("len1_valid_after", s_ov, 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("len1_done_single", s_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
